// File: rtl/frame_block_mover_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_block_mover_if
// Purpose  : Pixel-plot request/acknowledge bus between the block mover
//            (master) and the VGA plotter (slave).
// Signals  : plot_req    - pixel write request (master -> slave)
//            plot_ack    - plotter accepted current pixel (slave -> master)
//            plot_x      - pixel x coordinate
//            plot_y      - pixel y coordinate
//            plot_colour - 3-bit pixel colour
// Revision : 1.0 - initial release
// ============================================================================
interface frame_block_mover_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) ();

  logic           plot_req;
  logic           plot_ack;
  logic [X_W-1:0] plot_x;
  logic [Y_W-1:0] plot_y;
  logic [2:0]     plot_colour;

  modport master (
    output plot_req,
    output plot_x,
    output plot_y,
    output plot_colour,
    input  plot_ack
  );

  modport slave (
    input  plot_req,
    input  plot_x,
    input  plot_y,
    input  plot_colour,
    output plot_ack
  );

endinterface : frame_block_mover_if
`default_nettype wire

// File: rtl/frame_block_mover.sv
`default_nettype none
// ============================================================================
// Module   : frame_block_mover
// Purpose  : On each frame tick, erases a 1-row moving block, steps it one
//            pixel horizontally (bouncing at the screen edges) and redraws it
//            through a req/ack pixel plotter. A stop request freezes the block
//            once it is fully drawn.
// Ports    : clk         - system clock
//            reset       - asynchronous active-high reset
//            enable      - game running; gates tick acceptance and start-up
//            frame_tick  - one-cycle frame pulse
//            stop        - one-cycle player stop pulse
//            y_row       - block row, latched at the start of each pass
//            plot        - pixel plot bus (master side)
//            block_x     - current block left edge
//            stopped     - block frozen
//            overrun     - sticky: tick lost while one already pending
// Revision : 1.0 - initial release
// ============================================================================
module frame_block_mover #(
  parameter int          X_MAX   = 160,
  parameter int          BLOCK_W = 4,
  parameter int          X_W     = 8,
  parameter int          Y_W     = 7,
  parameter logic [2:0]  COLOUR  = 3'b111
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             enable,
  input  wire logic             frame_tick,
  input  wire logic             stop,
  input  wire logic [Y_W-1:0]   y_row,
  frame_block_mover_if.master   plot,
  output logic      [X_W-1:0]   block_x,
  output logic                  stopped,
  output logic                  overrun
);

  // Pixel index must be able to hold BLOCK_W: it marks "pass finished".
  localparam int                 c_IDX_W  = $clog2(BLOCK_W + 1);
  localparam logic [c_IDX_W-1:0] c_IDX_END = c_IDX_W'(BLOCK_W);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);
  localparam logic [X_W-1:0]     c_X_LAST  = X_W'(X_MAX - BLOCK_W);
  localparam logic [X_W-1:0]     c_X_ONE   = X_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRAW    = 3'd1,
    S_WAIT    = 3'd2,
    S_ERASE   = 3'd3,
    S_STEP    = 3'd4,
    S_STOPPED = 3'd5
  } state_t;

  state_t               r_state,     w_state_nx;
  logic [X_W-1:0]       r_x,         w_x_nx;
  logic                 r_dir_left,  w_dir_left_nx;
  logic                 r_pend_tick, w_pend_tick_nx;
  logic                 r_pend_stop, w_pend_stop_nx;
  logic                 r_overrun,   w_overrun_nx;
  logic                 r_req,       w_req_nx;
  logic [c_IDX_W-1:0]   r_idx,       w_idx_nx;
  logic [Y_W-1:0]       r_y,         w_y_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_dir_left  <= 1'b0;
      r_pend_tick <= 1'b0;
      r_pend_stop <= 1'b0;
      r_overrun   <= 1'b0;
      r_req       <= 1'b0;
      r_idx       <= '0;
      r_y         <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_x         <= w_x_nx;
      r_dir_left  <= w_dir_left_nx;
      r_pend_tick <= w_pend_tick_nx;
      r_pend_stop <= w_pend_stop_nx;
      r_overrun   <= w_overrun_nx;
      r_req       <= w_req_nx;
      r_idx       <= w_idx_nx;
      r_y         <= w_y_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_x_nx         = r_x;
    w_dir_left_nx  = r_dir_left;
    w_pend_tick_nx = r_pend_tick;
    w_pend_stop_nx = r_pend_stop;
    w_overrun_nx   = r_overrun;
    w_req_nx       = r_req;
    w_idx_nx       = r_idx;
    w_y_nx         = r_y;

    // Ticks and stops arriving while a frame update is in flight are
    // remembered and acted on once the block is back in WAIT.
    if (r_state == S_ERASE || r_state == S_STEP || r_state == S_DRAW) begin
      if (frame_tick) begin
        if (r_pend_tick) w_overrun_nx   = 1'b1;
        else             w_pend_tick_nx = 1'b1;
      end
      if (stop) w_pend_stop_nx = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nx = S_DRAW;
          w_req_nx   = 1'b1;
          w_idx_nx   = '0;
          w_y_nx     = y_row;
        end
      end

      // Each pixel: req high until ack, then one low cycle. The low cycle
      // after the last pixel is where the pass hands over.
      S_ERASE, S_DRAW: begin
        if (r_req) begin
          if (plot.plot_ack) begin
            w_req_nx = 1'b0;
            w_idx_nx = r_idx + c_IDX_ONE;
          end
        end else if (r_idx == c_IDX_END) begin
          w_state_nx = (r_state == S_ERASE) ? S_STEP : S_WAIT;
        end else begin
          w_req_nx = 1'b1;
        end
      end

      // Bounds are checked before moving, so the edge case reverses and
      // steps inward in the same cycle without ever wrapping.
      S_STEP: begin
        if (!r_dir_left) begin
          if (r_x == c_X_LAST) begin
            w_dir_left_nx = 1'b1;
            w_x_nx        = r_x - c_X_ONE;
          end else begin
            w_x_nx = r_x + c_X_ONE;
          end
        end else begin
          if (r_x == '0) begin
            w_dir_left_nx = 1'b0;
            w_x_nx        = r_x + c_X_ONE;
          end else begin
            w_x_nx = r_x - c_X_ONE;
          end
        end
        w_state_nx = S_DRAW;
        w_req_nx   = 1'b1;
        w_idx_nx   = '0;
        w_y_nx     = y_row;
      end

      // Stop beats a simultaneous tick; the tick is simply dropped.
      S_WAIT: begin
        if (r_pend_stop || stop) begin
          w_state_nx = S_STOPPED;
        end else if (r_pend_tick || (frame_tick && enable)) begin
          w_state_nx     = S_ERASE;
          w_pend_tick_nx = 1'b0;
          w_req_nx       = 1'b1;
          w_idx_nx       = '0;
          w_y_nx         = y_row;
        end
      end

      S_STOPPED: begin
        w_req_nx = 1'b0;
      end

      default: begin
        w_state_nx = S_IDLE;
        w_req_nx   = 1'b0;
      end
    endcase
  end

  assign plot.plot_req    = r_req;
  assign plot.plot_x      = r_x + X_W'(r_idx);
  assign plot.plot_y      = r_y;
  assign plot.plot_colour = (r_state == S_DRAW) ? COLOUR : 3'b000;

  assign block_x = r_x;
  assign stopped = (r_state == S_STOPPED);
  assign overrun = r_overrun;

endmodule : frame_block_mover
`default_nettype wire

// File: tb/tb_frame_block_mover.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_block_mover
// Purpose  : Directed self-checking bench for frame_block_mover with a
//            16-pixel screen and 4-pixel block; the plotter acknowledges
//            after a programmable number of request cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_block_mover;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       frame_tick;
  logic       stop;
  logic [6:0] y_row;
  logic [7:0] block_x;
  logic       stopped;
  logic       overrun;

  frame_block_mover_if #(.X_W(8), .Y_W(7)) pif ();

  frame_block_mover #(
    .X_MAX(16), .BLOCK_W(4), .X_W(8), .Y_W(7), .COLOUR(3'b111)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .frame_tick (frame_tick),
    .stop       (stop),
    .y_row      (y_row),
    .plot       (pif.master),
    .block_x    (block_x),
    .stopped    (stopped),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plotter model: ack in the ack_delay-th consecutive request cycle.
  int ack_delay = 1;
  int ack_cnt   = 0;
  assign pif.plot_ack = pif.plot_req && (ack_cnt >= ack_delay - 1);

  always @(posedge clk) begin
    if (pif.plot_req && !pif.plot_ack) ack_cnt <= ack_cnt + 1;
    else                               ack_cnt <= 0;
  end

  // Monitor: log accepted pixels, count request cycles, and flag any
  // change of x/y/colour while a request is waiting for its ack.
  pix_t pix_q[$];
  pix_t hold;
  logic hold_v     = 1'b0;
  int   req_cycles = 0;
  int   stab_err   = 0;

  always @(negedge clk) begin
    if (reset || !pif.plot_req) begin
      hold_v <= 1'b0;
    end else begin
      req_cycles <= req_cycles + 1;
      if (hold_v && ({pif.plot_x, pif.plot_y, pif.plot_colour} !== hold))
        stab_err <= stab_err + 1;
      if (pif.plot_ack) begin
        hold_v <= 1'b0;
        pix_q.push_back({pif.plot_x, pif.plot_y, pif.plot_colour});
      end else begin
        hold_v <= 1'b1;
        hold   <= {pif.plot_x, pif.plot_y, pif.plot_colour};
      end
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  int   exp_x;
  logic exp_left;
  int   snap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pix(input int n, input int budget);
    int k = 0;
    while (pix_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("pixel_timeout", 32'(pix_q.size() >= n), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Pops four pixels and compares each against base+i in row y_row.
  task automatic check_pass(input string tag, input int base, input logic [2:0] col);
    pix_t p;
    pix_t e;
    for (int i = 0; i < 4; i++) begin
      if (pix_q.size() > 0) p = pix_q.pop_front();
      else                  p = 'x;
      e.x = 8'(base + i);
      e.y = y_row;
      e.c = col;
      chk(tag, 32'(p), 32'(e));
    end
  endtask

  task automatic tick_pulse();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // One full frame with the reference bounce model.
  task automatic do_frame();
    int old_x;
    old_x = exp_x;
    tick_pulse();
    wait_pix(8, 200);
    if (!exp_left) begin
      if (exp_x == 12) begin exp_left = 1'b1; exp_x = exp_x - 1; end
      else exp_x = exp_x + 1;
    end else begin
      if (exp_x == 0) begin exp_left = 1'b0; exp_x = exp_x + 1; end
      else exp_x = exp_x - 1;
    end
    check_pass("frame_erase", old_x, 3'd0);
    check_pass("frame_draw", exp_x, 3'd7);
    chk("frame_block_x", 32'(block_x), 32'(exp_x));
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    frame_tick = 1'b0;
    stop       = 1'b0;
    y_row      = 7'd5;
    repeat (3) @(negedge clk);
    chk("rst_req",     32'(pif.plot_req),    32'd0);
    chk("rst_x",       32'(pif.plot_x),      32'd0);
    chk("rst_y",       32'(pif.plot_y),      32'd0);
    chk("rst_colour",  32'(pif.plot_colour), 32'd0);
    chk("rst_block_x", 32'(block_x),         32'd0);
    chk("rst_stopped", 32'(stopped),         32'd0);
    chk("rst_overrun", 32'(overrun),         32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_req", 32'(pif.plot_req), 32'd0);

    // Initial draw at x=0, then quiet in WAIT.
    enable = 1'b1;
    wait_pix(4, 100);
    check_pass("init_draw", 0, 3'd7);
    repeat (5) @(negedge clk);
    chk("init_quiet", 32'(pix_q.size()), 32'd0);
    exp_x    = 0;
    exp_left = 1'b0;

    // First frame, then run to the right edge and bounce.
    do_frame();
    chk("first_x", 32'(block_x), 32'd1);
    for (int i = 0; i < 11; i++) do_frame();
    chk("right_edge_x", 32'(block_x), 32'd12);
    do_frame();
    chk("bounce_left_x", 32'(block_x), 32'd11);
    for (int i = 0; i < 11; i++) do_frame();
    chk("left_edge_x", 32'(block_x), 32'd0);
    do_frame();
    chk("bounce_right_x", 32'(block_x), 32'd1);

    // Tick with enable low in WAIT is ignored.
    enable = 1'b0;
    tick_pulse();
    repeat (5) @(negedge clk);
    chk("disabled_tick_pix", 32'(pix_q.size()), 32'd0);
    chk("disabled_tick_x",   32'(block_x),      32'd1);
    enable = 1'b1;

    // Stretched acks, a pending tick and an overrun.
    ack_delay = 5;
    tick_pulse();
    repeat (10) @(negedge clk);
    tick_pulse();
    chk("pending_no_overrun", 32'(overrun), 32'd0);
    repeat (10) @(negedge clk);
    tick_pulse();
    chk("overrun_set", 32'(overrun), 32'd1);
    wait_pix(16, 400);
    check_pass("slow_erase1", 1, 3'd0);
    check_pass("slow_draw1",  2, 3'd7);
    check_pass("slow_erase2", 2, 3'd0);
    check_pass("slow_draw2",  3, 3'd7);
    chk("slow_block_x", 32'(block_x), 32'd3);
    chk("slow_stable",  32'(stab_err), 32'd0);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    ack_delay = 1;
    exp_x     = 3;

    // Stop during the draw at x=5.
    do_frame();
    tick_pulse();
    wait_pix(5, 100);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_pix(8, 100);
    check_pass("stop_erase", 4, 3'd0);
    check_pass("stop_draw",  5, 3'd7);
    repeat (3) @(negedge clk);
    chk("stop_stopped", 32'(stopped), 32'd1);
    chk("stop_block_x", 32'(block_x), 32'd5);
    snap = req_cycles;
    tick_pulse();
    tick_pulse();
    repeat (10) @(negedge clk);
    chk("stopped_no_req", 32'(req_cycles - snap), 32'd0);
    chk("stopped_hold_x", 32'(block_x), 32'd5);

    // Reset, then reset again mid-erase while a request is up.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_pix(4, 100);
    check_pass("rst_redraw", 0, 3'd7);
    chk("rst2_overrun", 32'(overrun), 32'd0);
    chk("rst2_stopped", 32'(stopped), 32'd0);
    tick_pulse();
    chk("mid_erase_req",    32'(pif.plot_req),    32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_req",     32'(pif.plot_req),    32'd0);
    chk("async_x",       32'(pif.plot_x),      32'd0);
    chk("async_y",       32'(pif.plot_y),      32'd0);
    chk("async_colour",  32'(pif.plot_colour), 32'd0);
    chk("async_block_x", 32'(block_x),         32'd0);
    pix_q.delete();
    y_row = 7'd9;
    @(negedge clk);
    reset = 1'b0;
    wait_pix(4, 100);
    check_pass("post_rst_draw", 0, 3'd7);

    // Stop and tick in the same WAIT cycle: stop wins, no erase.
    snap = req_cycles;
    @(negedge clk);
    stop       = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    stop       = 1'b0;
    frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    chk("tie_stopped", 32'(stopped), 32'd1);
    chk("tie_no_req",  32'(req_cycles - snap), 32'd0);
    chk("tie_block_x", 32'(block_x), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_frame_block_mover
`default_nettype wire

// File: doc/frame_block_mover.md
Name: frame_block_mover

Overview:
- Consumer end of the frame-enable interface driven by the frame delay counter.
- On each one-cycle frame tick, erases the moving block, steps it one pixel horizontally with bounce at the screen edges, and redraws it.
- Pixel writes go through a req/ack handshake to the VGA plotter.
- A player stop request freezes the block in place so the game logic can stack it.

Parameters:
X_MAX, 160, screen width in pixels; legal block x range is 0..X_MAX-BLOCK_W
BLOCK_W, 4, block width in pixels (height is 1 row)
X_W, 8, width of x coordinates
Y_W, 7, width of y coordinates
COLOUR, 3'b111, draw colour; erase colour is 3'b000

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  game running; gates tick acceptance and start-up
frame_tick  in  1  one-cycle pulse from frame delay counter
stop  in  1  one-cycle player stop pulse
y_row  in  Y_W  row the block occupies; sampled at start of each erase/draw pass
plot_req  out  1  pixel write request
plot_ack  in  1  plotter accepted current pixel
plot_x  out  X_W  pixel x
plot_y  out  Y_W  pixel y
plot_colour  out  3  pixel colour
block_x  out  X_W  current block left edge
stopped  out  1  block frozen
overrun  out  1  sticky: tick lost while one already pending

Behaviour:
- Reset (async, immediate, also mid-handshake):
  - all outputs 0, plot_req drops at once.
  - dir=right, pending_tick=0, pending_stop=0, state=IDLE.
- States: IDLE, DRAW, WAIT, ERASE, STEP, STOPPED.
- IDLE: on enable=1 go to DRAW, giving an initial draw at x=0 with no step.
- Pixel pass (ERASE and DRAW):
  - Plots BLOCK_W pixels at x=block_x+i, i=0..BLOCK_W-1, ascending; plot_y=y_row latched at pass start.
  - plot_colour=0 in ERASE, COLOUR in DRAW.
  - plot_req rises with x/y/colour valid.
  - req, x, y and colour are held stable until the cycle plot_ack=1 is sampled.
  - req is low the following cycle; the next pixel request rises the cycle after.
  - plot_ack while req=0 is ignored.
  - After the last ack: ERASE goes to STEP; DRAW goes to WAIT.
- STEP (one cycle), then DRAW:
  - dir right: if block_x+BLOCK_W==X_MAX then dir=left and block_x-=1, else block_x+=1.
  - dir left: if block_x==0 then dir=right and block_x+=1, else block_x-=1.
  - block_x never leaves 0..X_MAX-BLOCK_W.
  - Arithmetic is X_W bits; the bounds check precedes the update, so no wrap.
- WAIT:
  - pending_stop or stop=1 -> STOPPED.
  - Else pending_tick or (frame_tick=1 and enable=1) -> ERASE, clearing pending_tick.
  - Ticks with enable=0 in WAIT are ignored.
- Ticks outside WAIT:
  - frame_tick in any non-IDLE, non-STOPPED state other than WAIT sets pending_tick.
  - If pending_tick is already 1, set overrun instead; overrun is sticky until reset.
- Stop outside WAIT:
  - stop during ERASE/STEP/DRAW sets pending_stop.
  - It takes effect on entry to WAIT, so the block is always left fully drawn.
- Simultaneous stop and tick in WAIT: stop wins; the tick is discarded.
- STOPPED: terminal until reset; stopped=1, plot_req=0, block_x held, ticks and stop ignored (no overrun).
- Latency: from a tick accepted in WAIT, ERASE starts next cycle.
  - Minimum frame update = 1 + 2*BLOCK_W*2 + 1 cycles with single-cycle acks.
- enable falling mid-pass does not abort the pass.

Test Plan:
- BLOCK_W=4, X_MAX=16, ack tied to req, enable=1 after reset:
  - initial draw plots x=0..3 colour 7, then idle in WAIT.
  - one tick -> erase x=0..3 colour 0, then draw x=1..4 colour 7; block_x=1.
- Bounce: 12 ticks -> block_x reaches 12; 13th tick -> block_x=11, dir left.
  - Continue to x=0; next tick -> block_x=1.
- Ack stretched 5 cycles: plot_x/y/colour stable throughout; second tick mid-pass sets pending and runs immediately after DRAW; a third tick during the same pass asserts overrun=1.
- Stop during DRAW at x=5: draw completes, stopped=1, block_x=5; later ticks produce no plot_req.
- Stop and tick in the same WAIT cycle -> stopped=1, no erase.
- Reset asserted mid-ERASE with plot_req=1: req drops in the same cycle, all outputs 0; after release with enable=1, initial draw at x=0 repeats.
